// File: rtl/reversi_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// reversi_pkg : cell codes, initial board, direction deltas, FSM states (rev 1.0)
// -----------------------------------------------------------------------------
package reversi_pkg;

  localparam logic [2:0] EMPTY  = 3'b000;
  localparam logic [2:0] ENABLE = 3'b100;
  localparam logic [2:0] WHITE  = 3'b110;
  localparam logic [2:0] BLACK  = 3'b111;

  localparam logic [191:0] INIT_BOARD =
      (192'(WHITE) << 81)  | (192'(BLACK) << 84) |
      (192'(BLACK) << 105) | (192'(WHITE) << 108);

  // Two's-complement deltas, index 0..7 = N, NE, E, SE, S, SW, W, NW
  localparam logic [7:0][1:0] DX = {2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
  localparam logic [7:0][1:0] DY = {2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11};

  typedef enum logic [2:0] {IDLE, CHECK, WALK, FLIP, COMMIT, DONE} state_t;

  function automatic logic is_disc(input logic [2:0] code);
    return (code == WHITE) || (code == BLACK);
  endfunction

  function automatic logic is_empty(input logic [2:0] code);
    return (code == EMPTY) || (code == ENABLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reversi_cursor_step.sv
`default_nettype none
// -----------------------------------------------------------------------------
// reversi_cursor_step : one-cell step of a 4-bit cursor along direction dir (rev 1.0)
// -----------------------------------------------------------------------------
module reversi_cursor_step
  import reversi_pkg::*;
(
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  input  logic [2:0] dir,
  output logic [3:0] next_x,
  output logic [3:0] next_y,
  output logic       in_bounds
);

  logic [1:0] dx;
  logic [1:0] dy;

  assign dx = DX[dir];
  assign dy = DY[dir];

  assign next_x = cur_x + {{2{dx[1]}}, dx};
  assign next_y = cur_y + {{2{dy[1]}}, dy};

  // -1 wraps to 15 and 7+1 gives 8: both set bit 3, so no wrap can look legal
  assign in_bounds = ~next_x[3] & ~next_y[3];

endmodule
`default_nettype wire

// File: rtl/reversi_move_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// reversi_move_ctrl : board owner, move legality walk, disc flipping (rev 1.0)
// -----------------------------------------------------------------------------
module reversi_move_ctrl
  import reversi_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         go,
  input  logic [2:0]   x,
  input  logic [2:0]   y,
  output logic         busy,
  output logic         done,
  output logic         legal,
  output logic         player_black,
  output logic [6:0]   black_count,
  output logic [6:0]   white_count,
  output logic         game_over,
  output logic [191:0] board_result
);

  state_t     state;
  logic [2:0] org_x, org_y;
  logic [2:0] dir;
  logic [2:0] run;
  logic [3:0] cur_x, cur_y;
  logic       cur_ok;
  logic       any_flip;

  logic [3:0] adv_x, adv_y, rl_x, rl_y;
  logic       adv_ok, rl_ok;
  logic [2:0] rl_dir;
  logic [7:0] cur_base, org_base;
  logic [2:0] cur_cell, org_cell;
  logic [2:0] own, opp;
  logic       walk_opp, walk_cap, last_dir;

  assign own = player_black ? BLACK : WHITE;
  assign opp = player_black ? WHITE : BLACK;

  assign cur_base = {1'b0, cur_y[2:0], cur_x[2:0], 1'b0} + {2'b00, cur_y[2:0], cur_x[2:0]};
  assign org_base = {1'b0, org_y, org_x, 1'b0} + {2'b00, org_y, org_x};
  assign cur_cell = board_result[cur_base +: 3];
  assign org_cell = board_result[org_base +: 3];

  assign walk_opp = cur_ok && !is_empty(cur_cell) && (cur_cell == opp);
  assign walk_cap = cur_ok && !is_empty(cur_cell) && (cur_cell == own) && (run != 3'd0);
  assign last_dir = (dir == 3'd7);

  // Reload targets the first cell of direction 0 from CHECK, the current
  // direction when a capture starts, and the next direction otherwise.
  assign rl_dir = (state == CHECK)            ? 3'd0 :
                  (state == WALK && walk_cap) ? dir  : dir + 3'd1;

  assign game_over = ({1'b0, black_count} + {1'b0, white_count}) == 8'd64;

  reversi_cursor_step u_adv (
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .dir       (dir),
    .next_x    (adv_x),
    .next_y    (adv_y),
    .in_bounds (adv_ok)
  );

  reversi_cursor_step u_reload (
    .cur_x     ({1'b0, org_x}),
    .cur_y     ({1'b0, org_y}),
    .dir       (rl_dir),
    .next_x    (rl_x),
    .next_y    (rl_y),
    .in_bounds (rl_ok)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state        <= IDLE;
      board_result <= INIT_BOARD;
      player_black <= 1'b1;
      black_count  <= 7'd2;
      white_count  <= 7'd2;
      busy         <= 1'b0;
      done         <= 1'b0;
      legal        <= 1'b0;
      org_x        <= 3'd0;
      org_y        <= 3'd0;
      dir          <= 3'd0;
      run          <= 3'd0;
      cur_x        <= 4'd0;
      cur_y        <= 4'd0;
      cur_ok       <= 1'b0;
      any_flip     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            org_x    <= x;
            org_y    <= y;
            any_flip <= 1'b0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (is_disc(org_cell)) begin
            legal <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            dir    <= 3'd0;
            run    <= 3'd0;
            cur_x  <= rl_x;
            cur_y  <= rl_y;
            cur_ok <= rl_ok;
            state  <= WALK;
          end
        end
        WALK: begin
          if (walk_opp) begin
            run    <= run + 3'd1;
            cur_x  <= adv_x;
            cur_y  <= adv_y;
            cur_ok <= adv_ok;
          end else if (walk_cap) begin
            any_flip <= 1'b1;
            cur_x    <= rl_x;
            cur_y    <= rl_y;
            cur_ok   <= rl_ok;
            state    <= FLIP;
          end else if (last_dir) begin
            state <= COMMIT;
          end else begin
            dir    <= dir + 3'd1;
            run    <= 3'd0;
            cur_x  <= rl_x;
            cur_y  <= rl_y;
            cur_ok <= rl_ok;
          end
        end
        FLIP: begin
          board_result[cur_base +: 3] <= own;
          if (player_black) begin
            black_count <= black_count + 7'd1;
            white_count <= white_count - 7'd1;
          end else begin
            white_count <= white_count + 7'd1;
            black_count <= black_count - 7'd1;
          end
          run <= run - 3'd1;
          if (run != 3'd1) begin
            cur_x  <= adv_x;
            cur_y  <= adv_y;
            cur_ok <= adv_ok;
          end else if (last_dir) begin
            state <= COMMIT;
          end else begin
            dir    <= dir + 3'd1;
            run    <= 3'd0;
            cur_x  <= rl_x;
            cur_y  <= rl_y;
            cur_ok <= rl_ok;
            state  <= WALK;
          end
        end
        COMMIT: begin
          if (any_flip) begin
            board_result[org_base +: 3] <= own;
            if (player_black) black_count <= black_count + 7'd1;
            else              white_count <= white_count + 7'd1;
            player_black <= ~player_black;
          end
          legal <= any_flip;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          legal <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reversi_move_ctrl.sv
`default_nettype none
// Bench for reversi_move_ctrl: directed table, multi-cycle corner sequences and
// random play compared against an array-based reversi rules model.
module tb_reversi_move_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic         go;
  logic [2:0]   x, y;
  logic         busy, done, legal, player_black, game_over;
  logic [6:0]   black_count, white_count;
  logic [191:0] board_result;

  reversi_move_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .go           (go),
    .x            (x),
    .y            (y),
    .busy         (busy),
    .done         (done),
    .legal        (legal),
    .player_black (player_black),
    .black_count  (black_count),
    .white_count  (white_count),
    .game_over    (game_over),
    .board_result (board_result)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] C_EMPTY = 3'b000;
  localparam logic [2:0] C_WHITE = 3'b110;
  localparam logic [2:0] C_BLACK = 3'b111;

  int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dys [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  logic [2:0] mb [64];
  bit         mpb;
  int         cand [$];
  int         checks = 0;
  int         errors = 0;
  int         multi_seen = 0;

  typedef struct {
    int tx; int ty; bit exp_legal; int exp_lat; int exp_black; int exp_white; bit exp_pb;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 64; i++) mb[i] = C_EMPTY;
    mb[27] = C_WHITE; mb[36] = C_WHITE;
    mb[28] = C_BLACK; mb[35] = C_BLACK;
    mpb = 1'b1;
  endtask

  function automatic logic [191:0] model_vec();
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v[3*i +: 3] = mb[i];
    return v;
  endfunction

  function automatic int model_count(input logic [2:0] code);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) if (mb[i] == code) c++;
    return c;
  endfunction

  // Opponent run length from (ox,oy) along d; closed = run ends on an own disc
  function automatic int ray(input int ox, input int oy, input int d, output bit closed);
    logic [2:0] own, opp;
    int k, cx, cy;
    own = mpb ? C_BLACK : C_WHITE;
    opp = mpb ? C_WHITE : C_BLACK;
    k = 0;
    cx = ox + dxs[d];
    cy = oy + dys[d];
    closed = 1'b0;
    while (cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && mb[cy*8+cx] == opp) begin
      k++;
      cx += dxs[d];
      cy += dys[d];
    end
    if (cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && mb[cy*8+cx] == own && k > 0) closed = 1'b1;
    return k;
  endfunction

  function automatic int flips_of(input int mx, input int my);
    bit cl;
    int k, s;
    s = 0;
    if (mb[my*8+mx] == C_WHITE || mb[my*8+mx] == C_BLACK) return 0;
    for (int d = 0; d < 8; d++) begin
      k = ray(mx, my, d, cl);
      if (cl) s += k;
    end
    return s;
  endfunction

  task automatic model_move(input int mx, input int my, output bit lg, output int lat);
    int len [8];
    bit cl [8];
    int t, big;
    logic [2:0] own;
    own = mpb ? C_BLACK : C_WHITE;
    t = 0; big = 0; lg = 1'b0;
    if (mb[my*8+mx] == C_WHITE || mb[my*8+mx] == C_BLACK) begin
      lat = 2;
      return;
    end
    for (int d = 0; d < 8; d++) begin
      len[d] = ray(mx, my, d, cl[d]);
      t += len[d] + 1;
      if (cl[d]) begin
        t += len[d];
        lg = 1'b1;
        if (len[d] >= 2) big++;
      end
    end
    lat = 3 + t;
    if (lg) begin
      for (int d = 0; d < 8; d++)
        if (cl[d])
          for (int k = 1; k <= len[d]; k++) mb[(my + k*dys[d])*8 + mx + k*dxs[d]] = own;
      mb[my*8+mx] = own;
      mpb = !mpb;
      if (big >= 3) multi_seen++;
    end
  endtask

  task automatic fill_cands();
    cand.delete();
    for (int c = 0; c < 64; c++) if (flips_of(c % 8, c / 8) > 0) cand.push_back(c);
  endtask

  // ---------------- DUT drivers ----------------
  task automatic reset_all();
    resetn = 1'b1;
    go = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic dut_move(input int mx, input int my, output bit lg, output int lat);
    x = 3'(mx);
    y = 3'(my);
    go = 1'b1;
    tick();
    go = 1'b0;
    lat = 1;
    while (!done && lat < 150) begin
      tick();
      lat++;
    end
    lg = legal;
    if (!done) lat = -1;
    tick();
  endtask

  task automatic compare_state(input string tag);
    check({tag, " board"}, board_result, model_vec());
    check({tag, " black_count"}, black_count, model_count(C_BLACK));
    check({tag, " white_count"}, white_count, model_count(C_WHITE));
    check({tag, " player_black"}, player_black, mpb);
    check({tag, " game_over"}, game_over, (model_count(C_BLACK) + model_count(C_WHITE)) == 64);
    check({tag, " done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    bit lg, mlg;
    int lat, mlat, pulses, pick, best, r;

    resetn = 1'b1; go = 1'b0; x = 3'd0; y = 3'd0;
    tbl[0] = '{0, 0, 1'b0, 11, 2, 2, 1'b1};
    tbl[1] = '{3, 2, 1'b1, 13, 4, 1, 1'b0};
    tbl[2] = '{3, 2, 1'b0, 2,  4, 1, 1'b0};
    tbl[3] = '{2, 2, 1'b1, 14, 3, 3, 1'b1};

    // reset state
    reset_all();
    check("reset board", board_result, model_vec());
    check("reset player", player_black, 1'b1);
    check("reset black_count", black_count, 7'd2);
    check("reset white_count", white_count, 7'd2);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset legal", legal, 1'b0);
    check("reset game_over", game_over, 1'b0);

    // directed table
    for (int i = 0; i < 4; i++) begin
      dut_move(tbl[i].tx, tbl[i].ty, lg, lat);
      model_move(tbl[i].tx, tbl[i].ty, mlg, mlat);
      check("tbl legal", lg, tbl[i].exp_legal);
      check("tbl latency", lat, tbl[i].exp_lat);
      check("tbl black_count", black_count, tbl[i].exp_black);
      check("tbl white_count", white_count, tbl[i].exp_white);
      check("tbl player", player_black, tbl[i].exp_pb);
      compare_state("tbl");
      if (i == 1) begin
        check("tbl cell19", board_result[59:57], C_BLACK);
        check("tbl cell27", board_result[83:81], C_BLACK);
      end
    end

    // go pulsed while busy is ignored
    reset_all();
    x = 3'd3; y = 3'd2; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    check("busy during move", busy, 1'b1);
    x = 3'd5; y = 3'd4; go = 1'b1;
    pulses = 0;
    tick();
    if (done) pulses++;
    go = 1'b0; x = 3'd0; y = 3'd0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) pulses++;
    end
    model_move(3, 2, mlg, mlat);
    check("busy go pulses", pulses, 1);
    compare_state("busy go");

    // reset asserted during FLIP of white (2,2): CHECK at cycle 1, FLIP at cycle 8
    reset_all();
    dut_move(3, 2, lg, lat);
    model_move(3, 2, mlg, mlat);
    x = 3'd2; y = 3'd2; go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("pre-reset busy", busy, 1'b1);
    #2 resetn = 1'b1;
    #1;
    model_reset();
    check("midreset board", board_result, model_vec());
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    tick();
    resetn = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) pulses++;
    end
    check("midreset no done", pulses, 0);
    check("midreset player", player_black, 1'b1);

    // go held high on an occupied cell: one request every 3 cycles
    reset_all();
    x = 3'd3; y = 3'd3; go = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done) pulses++;
      check("held done", done, (k % 3) == 2);
      check("held busy", busy, (k % 3) != 0);
    end
    go = 1'b0;
    check("held pulses", pulses, 10);
    tick(); tick(); tick();

    // random play against the model
    reset_all();
    for (int it = 0; it < 300; it++) begin
      fill_cands();
      if (cand.size() == 0) begin
        reset_all();
        continue;
      end
      r = $urandom_range(0, 9);
      if (r < 3) begin
        pick = $urandom_range(0, 63);
      end else if (r < 6) begin
        pick = cand[0];
        best = 0;
        foreach (cand[j]) begin
          if (flips_of(cand[j] % 8, cand[j] / 8) > best) begin
            best = flips_of(cand[j] % 8, cand[j] / 8);
            pick = cand[j];
          end
        end
      end else begin
        pick = cand[$urandom_range(0, cand.size() - 1)];
      end
      dut_move(pick % 8, pick / 8, lg, lat);
      model_move(pick % 8, pick / 8, mlg, mlat);
      check("rnd legal", lg, mlg);
      check("rnd latency", lat, mlat);
      check("rnd latency bound", lat <= 110, 1'b1);
      compare_state("rnd");
    end

    $display("multi-direction captures exercised: %0d", multi_seen);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
